// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled mid-bit sampling, valid/ack holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with an extra o_parity_error pulse.
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 9_600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ack,
  output logic       o_framing_error,
  output logic       o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_error,
`endif
  output logic       o_busy
);

  localparam int DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_sync;
  logic                   r_rx_prev;
  logic [DW-1:0]          r_div;
  logic [TW-1:0]          r_tick;
  logic [BW-1:0]          r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_deliver;
`ifdef UART_RX_PARITY_EN
  logic                   r_parity;
`endif

  logic w_rx;
  logic w_tick;
  logic w_full;

  assign w_rx   = r_sync[1];
  assign w_tick = (r_div == DIV_LAST);
  assign w_full = w_tick && (r_tick == FULL_LAST);
  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_sync          <= 2'b11;
      r_rx_prev       <= 1'b1;
      r_div           <= '0;
      r_tick          <= '0;
      r_bit           <= '0;
      r_shift         <= '0;
      r_deliver       <= 1'b0;
      o_rx_data       <= '0;
      o_rx_valid      <= 1'b0;
      o_framing_error <= 1'b0;
      o_overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity        <= 1'b0;
      o_parity_error  <= 1'b0;
`endif
    end else begin
      r_sync          <= {r_sync[0], i_rx_serial};
      r_rx_prev       <= w_rx;
      r_div           <= w_tick ? '0 : r_div + 1'b1;
      r_deliver       <= 1'b0;
      o_framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_error  <= 1'b0;
`endif
      if (w_tick && !w_full) r_tick <= r_tick + 1'b1;

      unique case (r_state)
        S_IDLE: begin
          // Restart the divider so sample points sit mid-bit.
          if (r_rx_prev && !w_rx) begin
            r_state <= S_START;
            r_div   <= '0;
            r_tick  <= '0;
          end
        end
        S_START: begin
          if (w_tick && r_tick == HALF_LAST) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_tick  <= '0;
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bit   <= r_bit + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (r_bit == BIT_LAST) r_state <= S_PARITY;
`else
            if (r_bit == BIT_LAST) r_state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_full) begin
            r_tick   <= '0;
            r_parity <= w_rx;
            r_state  <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_full) begin
            r_tick <= '0;
            if (w_rx) begin
              r_deliver <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              o_framing_error <= 1'b1;
              r_state         <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (r_deliver) begin
        if (!o_rx_valid || i_rx_ack) begin
          o_rx_data  <= 8'(r_shift);
          o_rx_valid <= 1'b1;
          o_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
          o_parity_error <= ^{r_shift, r_parity};
`endif
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ack) begin
        o_rx_valid <= 1'b0;
        o_overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized bench for uart_receiver at 160 clk/bit.
// A holding-register model tracks the expected data/valid/overrun.
module tb_uart_receiver;

  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       fe;
  logic       ovr;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
  int         pe_cnt = 0;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   fe_cnt = 0;
  int   rise_cyc = 0;
  int   stop_cyc = 0;
  logic prev_valid = 1'b0;

  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;

  uart_receiver #(
    .CLK_FREQ_HZ(1_600_000),
    .BAUD(10_000),
    .OVERSAMPLE(16),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_rx_serial(rx),
    .o_rx_data(rx_data),
    .o_rx_valid(rx_valid),
    .i_rx_ack(ack),
    .o_framing_error(fe),
    .o_overrun(ovr),
`ifdef UART_RX_PARITY_EN
    .o_parity_error(perr),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (fe) fe_cnt = fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (perr) pe_cnt = pe_cnt + 1;
`endif
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_data"}, {24'h0, rx_data}, {24'h0, m_data});
    chk({tag, "_valid"}, {31'h0, rx_valid}, {31'h0, m_valid});
    chk({tag, "_overrun"}, {31'h0, ovr}, {31'h0, m_ovr});
  endtask

  // Holding-register rules: load when empty or acked this cycle, else drop.
  task automatic model_deliver(input logic [7:0] b, input logic ack_now);
    if (!m_valid || ack_now) begin
      m_data  = b;
      m_valid = 1'b1;
      m_ovr   = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d,
                                        input logic stop,
                                        input logic pflip);
`ifdef UART_RX_PARITY_EN
    return {stop, (^d) ^ pflip, d, 1'b0};
`else
    return {1'b0 & pflip, stop, d, 1'b0};
`endif
  endfunction

  task automatic send_bits(input logic [10:0] bits);
    for (int i = 0; i < NBITS; i++) begin
      if (i == NBITS - 1) stop_cyc = cyc;
      rx = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(frame(d, 1'b1, 1'b0));
  endtask

  task automatic check_latency(input string tag);
    int d;
    d = rise_cyc - stop_cyc;
    chk({tag, "_latency"}, {31'h0, (d >= 80 && d <= 90)}, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int delta;

    repeat (3) @(negedge clk);
    chk("rst_data", {24'h0, rx_data}, 32'h0);
    chk("rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_fe", {31'h0, fe}, 32'h0);
    chk("rst_ovr", {31'h0, ovr}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    send_frame(8'hA5);
    model_deliver(8'hA5, 1'b0);
    check_out("t1");
    chk("t1_fe", fe_cnt, 32'd0);
    check_latency("t1");
    delta = rise_cyc - stop_cyc;
    do_ack();
    check_out("t1_ack");

    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      send_frame(b);
      model_deliver(b, 1'b0);
      check_out("rnd");
      check_latency("rnd");
      do_ack();
      check_out("rnd_ack");
    end

    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("t2_busy_glitch", {31'h0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("t2_busy_idle", {31'h0, busy}, 32'd0);
    chk("t2_valid", {31'h0, rx_valid}, 32'd0);
    chk("t2_fe", fe_cnt, 32'd0);

    send_bits(frame(8'h3C, 1'b0, 1'b0));
    repeat (500) @(negedge clk);
    chk("t3_fe_once", fe_cnt, 32'd1);
    chk("t3_valid", {31'h0, rx_valid}, 32'd0);
    chk("t3_busy_break", {31'h0, busy}, 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_busy_release", {31'h0, busy}, 32'd0);
    repeat (300) @(negedge clk);
    chk("t3_no_frame", {31'h0, rx_valid}, 32'd0);
    chk("t3_fe_final", fe_cnt, 32'd1);

    send_frame(8'h11);
    model_deliver(8'h11, 1'b0);
    send_frame(8'h22);
    model_deliver(8'h22, 1'b0);
    check_out("t4_ovr");
    do_ack();
    check_out("t4_ack");
    send_frame(8'h44);
    model_deliver(8'h44, 1'b0);
    check_out("t4_hold");
    fork
      send_frame(8'h33);
      begin
        repeat (9 * BIT_CLKS + delta - 1) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    model_deliver(8'h33, 1'b1);
    check_out("t4_ack_deliver");

    fork
      send_frame(8'hFF);
      begin
        repeat (4 * BIT_CLKS) @(negedge clk);
        chk("t5_busy_pre", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        check_out("t5_reset");
        chk("t5_busy_rst", {31'h0, busy}, 32'd0);
        chk("t5_fe_rst", {31'h0, fe}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    repeat (50) @(negedge clk);
    send_frame(8'h5A);
    model_deliver(8'h5A, 1'b0);
    check_out("t5_next");
    check_latency("t5");
    do_ack();

`ifdef UART_RX_PARITY_EN
    send_bits(frame(8'h07, 1'b1, 1'b0));
    model_deliver(8'h07, 1'b0);
    check_out("t6_good");
    chk("t6_no_perr", pe_cnt, 32'd0);
    do_ack();
    send_bits(frame(8'h07, 1'b1, 1'b1));
    model_deliver(8'h07, 1'b0);
    check_out("t6_bad");
    chk("t6_perr", pe_cnt, 32'd1);
    do_ack();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
